// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 256 x 32 data memory.
// All outputs are flops; read data is taken from mem_rdata on the edge that closes the strobe cycle.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arbState;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  arbState state, stateNext;
  logic lastGrant, lastGrantNext;
  logic gntId, gntIdNext;
  logic latWe, latWeNext;
  logic selId, selWe, inRange;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic memReadNext, memWriteNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext;
  logic [1:0] ackNext, errNext;
  logic [DATA_W-1:0] rdata0Next, rdata1Next;

  // On a tie the port that was not served last wins.
  assign selId    = (r0_req && r1_req) ? ~lastGrant : r1_req;
  assign selWe    = selId ? r1_we    : r0_we;
  assign selAddr  = selId ? r1_addr  : r0_addr;
  assign selWdata = selId ? r1_wdata : r0_wdata;
  assign inRange  = {1'b0, selAddr} < DEPTH_EXT;

  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    gntIdNext     = gntId;
    latWeNext     = latWe;
    memReadNext   = 1'b0;
    memWriteNext  = 1'b0;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    ackNext       = 2'b00;
    errNext       = 2'b00;
    rdata0Next    = r0_rdata;
    rdata1Next    = r1_rdata;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          gntIdNext     = selId;
          lastGrantNext = selId;
          latWeNext     = selWe;
          if (inRange) begin
            stateNext    = ACCESS;
            memReadNext  = !selWe;
            memWriteNext = selWe;
            memAddrNext  = selAddr;
            memWdataNext = selWdata;
          end else begin
            // Out-of-range: answer straight away, memory pins untouched.
            stateNext      = RESP;
            ackNext[selId] = 1'b1;
            errNext[selId] = 1'b1;
            if (selId) rdata1Next = '0;
            else       rdata0Next = '0;
          end
        end
      end
      ACCESS: begin
        stateNext      = RESP;
        ackNext[gntId] = 1'b1;
        if (gntId) rdata1Next = latWe ? '0 : mem_rdata;
        else       rdata0Next = latWe ? '0 : mem_rdata;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      gntId     <= 1'b0;
      latWe     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_ack    <= 1'b0;
      r0_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_ack    <= 1'b0;
      r1_err    <= 1'b0;
      r1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      gntId     <= gntIdNext;
      latWe     <= latWeNext;
      mem_read  <= memReadNext;
      mem_write <= memWriteNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      r0_ack    <= ackNext[0];
      r0_err    <= errNext[0];
      r0_rdata  <= rdata0Next;
      r1_ack    <= ackNext[1];
      r1_err    <= errNext[1];
      r1_rdata  <= rdata1Next;
      busy      <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, response scoreboard and per-scenario timing checks.
module tb_dmem_arbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r0_ack, r0_err;
  logic [31:0] r0_rdata;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r1_ack, r1_err;
  logic [31:0] r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  expT         exp0[$];
  expT         exp1[$];
  expT         mon;
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: data visible while the read strobe is up, garbage otherwise.
  assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 32'hBAD0F00D;
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] = mem_wdata;

  // Scoreboard and bus-level invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read || mem_write) begin
        total++;
        if (mem_read && mem_write) begin
          bad++; $display("FAIL strobe_excl got read=1 write=1 want at most one");
        end
      end
      if (r0_ack || r1_ack) begin
        total++;
        if (r0_ack && r1_ack) begin
          bad++; $display("FAIL ack_excl got both acks want one");
        end
      end
      if (r0_ack) begin
        total++;
        if (exp0.size() == 0) begin
          bad++; $display("FAIL r0_unexpected_ack got ack=1 want none");
        end else begin
          mon = exp0.pop_front();
          if (r0_rdata !== mon.rdata || r0_err !== mon.err) begin
            bad++; $display("FAIL r0_resp got rdata=%h err=%b want rdata=%h err=%b", r0_rdata, r0_err, mon.rdata, mon.err);
          end
        end
      end
      if (r1_ack) begin
        total++;
        if (exp1.size() == 0) begin
          bad++; $display("FAIL r1_unexpected_ack got ack=1 want none");
        end else begin
          mon = exp1.pop_front();
          if (r1_rdata !== mon.rdata || r1_err !== mon.err) begin
            bad++; $display("FAIL r1_resp got rdata=%h err=%b want rdata=%h err=%b", r1_rdata, r1_err, mon.rdata, mon.err);
          end
        end
      end
    end
  end

  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic track);
    expT e;
    e.err   = (addr >= 32'd256);
    e.rdata = (e.err || we) ? 32'h0 : shadow[addr[7:0]];
    if (track && !e.err && we) shadow[addr[7:0]] = wdata;
    if (port) begin
      r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
      if (track) exp1.push_back(e);
    end else begin
      r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
      if (track) exp0.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got %b want 0000000", {r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write, busy});
    end
    total++;
    if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_data got r0=%h r1=%h addr=%h wdata=%h want all 0", r0_rdata, r1_rdata, mem_addr, mem_wdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        bad++; $display("FAIL reset_idle got busy=%b rd=%b wr=%b want 0", busy, mem_read, mem_write);
      end
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL wr_idle got busy=%b wr=%b want 0 0", busy, mem_write);
    end
    @(negedge clk);
    total++;
    if ({mem_write, mem_read} !== 2'b10 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
      bad++; $display("FAIL wr_strobe got wr/rd=%b addr=%h wdata=%h busy=%b want 10 5 deadbeef 1", {mem_write, mem_read}, mem_addr, mem_wdata, busy);
    end
    @(negedge clk);
    total++;
    if (r0_ack !== 1'b1 || {mem_write, mem_read} !== 2'b00) begin
      bad++; $display("FAIL wr_ack got ack=%b wr/rd=%b want 1 00", r0_ack, {mem_write, mem_read});
    end
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd5, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({mem_write, mem_read} !== 2'b01 || mem_addr !== 32'd5) begin
      bad++; $display("FAIL rd_strobe got wr/rd=%b addr=%h want 01 5", {mem_write, mem_read}, mem_addr);
    end
    @(negedge clk);
    total++;
    if (r0_ack !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r0_err !== 1'b0) begin
      bad++; $display("FAIL rd_ack got ack=%b rdata=%h err=%b want 1 deadbeef 0", r0_ack, r0_rdata, r0_err);
    end
    @(posedge clk); #1; r0_req = 1'b0;
    @(negedge clk);
    total++;
    if (r0_ack !== 1'b0 || r0_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_hold got ack=%b rdata=%h want 0 deadbeef", r0_ack, r0_rdata);
    end
  endtask

  task automatic test_out_of_range();
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 32'd256, 32'h1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (r1_ack !== 1'b1 || r1_err !== 1'b1 || r1_rdata !== 32'h0 || {mem_write, mem_read} !== 2'b00) begin
      bad++; $display("FAIL oor_ack got ack=%b err=%b rdata=%h wr/rd=%b want 1 1 0 00", r1_ack, r1_err, r1_rdata, {mem_write, mem_read});
    end
    total++;
    if (r0_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL oor_other_hold got r0_rdata=%h want deadbeef", r0_rdata);
    end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'd255, 32'h0, 1'b1);
    @(negedge clk);
    total++;
    if ({mem_write, mem_read} !== 2'b00 || r1_ack !== 1'b0) begin
      bad++; $display("FAIL oor_after got wr/rd=%b ack=%b want 00 0", {mem_write, mem_read}, r1_ack);
    end
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd255) begin
      bad++; $display("FAIL edge_strobe got rd=%b addr=%h want 1 ff", mem_read, mem_addr);
    end
    @(negedge clk);
    total++;
    if (r1_ack !== 1'b1 || r1_err !== 1'b0) begin
      bad++; $display("FAIL edge_ack got ack=%b err=%b want 1 0", r1_ack, r1_err);
    end
    @(posedge clk); #1;
    r1_req = 1'b0;
    issue(1'b0, 1'b0, 32'h8000_0005, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (r0_ack !== 1'b1 || r0_err !== 1'b1 || {mem_write, mem_read} !== 2'b00) begin
      bad++; $display("FAIL hi_addr got ack=%b err=%b wr/rd=%b want 1 1 00", r0_ack, r0_err, {mem_write, mem_read});
    end
    @(posedge clk); #1; r0_req = 1'b0;
    @(negedge clk);
    total++;
    if (mem[0] !== shadow[0]) begin
      bad++; $display("FAIL oor_no_wrap got mem0=%h want %h", mem[0], shadow[0]);
    end
  endtask

  task automatic test_late_request();
    int strobeIdx = -1;
    int ackIdx = -1;
    logic [31:0] strobeAddr = '0;
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd50, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd50) begin
      bad++; $display("FAIL late_r0_strobe got rd=%b addr=%h want 1 32", mem_read, mem_addr);
    end
    issue(1'b1, 1'b0, 32'd60, 32'h0, 1'b1);
    @(negedge clk);
    total++;
    if (r0_ack !== 1'b1 || r1_ack !== 1'b0 || {mem_write, mem_read} !== 2'b00) begin
      bad++; $display("FAIL late_r0_ack got r0=%b r1=%b wr/rd=%b want 1 0 00", r0_ack, r1_ack, {mem_write, mem_read});
    end
    @(posedge clk); #1; r0_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read && strobeIdx < 0) begin strobeIdx = i; strobeAddr = mem_addr; end
      if (r1_ack) begin ackIdx = i; break; end
    end
    total++;
    if (strobeIdx !== 2 || strobeAddr !== 32'd60 || ackIdx !== 3) begin
      bad++; $display("FAIL late_r1 got strobe@%0d addr=%h ack@%0d want strobe@2 addr=3c ack@3", strobeIdx, strobeAddr, ackIdx);
    end
    @(posedge clk); #1; r1_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int ackIdx[$];
    logic [31:0] addrs[$];
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd0, 32'h0, 1'b1);
    for (int i = 0; i < 24 && n < 4; i++) begin
      @(negedge clk);
      if (mem_read) addrs.push_back(mem_addr);
      if (r0_ack) begin
        ackIdx.push_back(i);
        n++;
        @(posedge clk); #1;
        if (n < 4) issue(1'b0, 1'b0, 32'(n), 32'h0, 1'b1);
        else r0_req = 1'b0;
      end
    end
    total++;
    if (n !== 4 || addrs.size() !== 4) begin
      bad++; $display("FAIL b2b_count got acks=%0d strobes=%0d want 4 4", n, addrs.size());
      r0_req = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ackIdx[k] !== 2 + 3 * k || addrs[k] !== 32'(k)) begin
          bad++; $display("FAIL b2b_%0d got ack@%0d addr=%h want ack@%0d addr=%0d", k, ackIdx[k], addrs[k], 2 + 3 * k, k);
        end
      end
    end
  endtask

  task automatic test_contention();
    int n = 0;
    int ackIdx[$];
    logic [31:0] order[$];
    @(posedge clk); #1;
    rst = 1'b1;
    issue(1'b0, 1'b0, 32'd10, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'd10, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'd20, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'd20, 32'h0, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (mem_read) order.push_back(mem_addr);
      if (r0_ack || r1_ack) begin
        ackIdx.push_back(i);
        n++;
      end
    end
    @(posedge clk); #1; r0_req = 1'b0; r1_req = 1'b0;
    total++;
    if (n !== 4 || order.size() !== 4) begin
      bad++; $display("FAIL cont_count got acks=%0d grants=%0d want 4 4", n, order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (order[k] !== ((k % 2 == 0) ? 32'd10 : 32'd20) || ackIdx[k] !== 2 + 3 * k) begin
          bad++; $display("FAIL cont_%0d got addr=%0d ack@%0d want addr=%0d ack@%0d", k, order[k], ackIdx[k], (k % 2 == 0) ? 10 : 20, 2 + 3 * k);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic done0 = 1'b0, done1 = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 32'd7, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_write !== 1'b1) begin
      bad++; $display("FAIL rm_access got wr=%b want 1", mem_write);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({mem_write, mem_read, busy, r0_ack} !== 4'b0 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rm_async got wr/rd/busy/ack=%b addr=%h want 0000 0", {mem_write, mem_read, busy, r0_ack}, mem_addr);
    end
    r0_req = 1'b0;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({mem_write, mem_read, busy, r0_ack, r1_ack} !== 5'b0) begin
        bad++; $display("FAIL rm_quiet got wr/rd/busy/a0/a1=%b want 00000", {mem_write, mem_read, busy, r0_ack, r1_ack});
      end
    end
    total++;
    if (mem[7] !== shadow[7]) begin
      bad++; $display("FAIL rm_no_write got mem7=%h want %h", mem[7], shadow[7]);
    end
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd30, 32'h0, 1'b1);
    issue(1'b1, 1'b0, 32'd40, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd30) begin
      bad++; $display("FAIL rm_first_grant got rd=%b addr=%0d want 1 30", mem_read, mem_addr);
    end
    for (int i = 0; i < 15 && !(done0 && done1); i++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        if (r0_ack) done0 = 1'b1;
        if (r1_ack) done1 = 1'b1;
        @(posedge clk); #1;
        if (done0) r0_req = 1'b0;
        if (done1) r1_req = 1'b0;
      end
    end
    total++;
    if (!(done0 && done1)) begin
      bad++; $display("FAIL rm_drain got r0_done=%b r1_done=%b want 1 1", done0, done1);
      r0_req = 1'b0; r1_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      shadow[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    end
    test_reset();
    test_write_read();
    test_out_of_range();
    test_late_request();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (exp0.size() !== 0 || exp1.size() !== 0) begin
      bad++; $display("FAIL sb_drain got pending r0=%0d r1=%0d want 0 0", exp0.size(), exp1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
